debugger_rx: RTL and testbench

Command-receive and pipeline-control side of the debug unit. It pops 2-bit commands from the UART receive FIFO and decodes them into run-to-completion, single-step or software-reset actions. It drives the processor pipeline's generated clock and reset for each action. After every action it requests a state dump from the transmit side and waits for that to finish before accepting the next command.

---
 rtl/debugger_rx.sv | 96 +++++++++
 tb/tb_debugger_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_rx.sv
// Debug command receiver: pops 2-bit commands from the UART RX FIFO and drives
// the pipeline clock/reset for run, single-step and software-reset actions.
module debugger_rx (
  input  logic       clk,
  input  logic       global_reset,
  input  logic [1:0] r_data,
  input  logic       rx_empty,
  input  logic       program_finished,
  input  logic       data_sent,
  output logic       rd_uart,
  output logic       pipeline_reset,
  output logic       pipeline_clk,
  output logic       send_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    RUN     = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4,
    RST_HI  = 3'd5,
    RST_LO  = 3'd6,
    SEND    = 3'd7
  } state_t;

  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_ONE_STEP = 2'b01;
  localparam logic [1:0] CMD_RUN_ALL  = 2'b10;
  localparam logic [1:0] CMD_SW_RESET = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] cmd_q, cmd_d;
  logic       rd_d, prst_d, pclk_d, send_d;

  // Outputs are decoded from the next state and registered alongside it, so
  // every output lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          cmd_d   = r_data;
          state_d = POP;
        end
      end
      POP: begin
        case (cmd_q)
          CMD_RUN_ALL:  state_d = RUN;
          CMD_ONE_STEP: state_d = STEP_HI;
          CMD_SW_RESET: state_d = RST_HI;
          CMD_NOP:      state_d = IDLE;
          default:      state_d = IDLE;
        endcase
      end
      RUN:     if (program_finished) state_d = SEND;
      STEP_HI: state_d = STEP_LO;
      STEP_LO: state_d = SEND;
      RST_HI:  state_d = RST_LO;
      RST_LO:  state_d = SEND;
      SEND:    if (data_sent) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_d   = (state_d == POP);
    prst_d = (state_d == RST_HI) || (state_d == RST_LO);
    send_d = (state_d == SEND);
    pclk_d = 1'b0;
    case (state_d)
      // Free-running clk/2 while in RUN; the entry edge is always a rising one.
      RUN:             pclk_d = (state_q == RUN) ? ~pipeline_clk : 1'b1;
      STEP_HI, RST_HI: pclk_d = 1'b1;
      default:         pclk_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!global_reset) begin
      state_q        <= IDLE;
      cmd_q          <= CMD_NOP;
      rd_uart        <= 1'b0;
      pipeline_reset <= 1'b1;
      pipeline_clk   <= 1'b0;
      send_data      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      rd_uart        <= rd_d;
      pipeline_reset <= prst_d;
      pipeline_clk   <= pclk_d;
      send_data      <= send_d;
    end
  end

endmodule

// File: tb/tb_debugger_rx.sv
// Directed bench for debugger_rx: reset, each command, queued commands, no-op,
// SEND shortcut and mid-run abort, with hand-computed expected outputs.
module tb_debugger_rx;

  logic       clk;
  logic       global_reset;
  logic [1:0] r_data;
  logic       rx_empty;
  logic       program_finished;
  logic       data_sent;
  logic       rd_uart;
  logic       pipeline_reset;
  logic       pipeline_clk;
  logic       send_data;

  int checks = 0;
  int errors = 0;

  debugger_rx dut (
    .clk              (clk),
    .global_reset     (global_reset),
    .r_data           (r_data),
    .rx_empty         (rx_empty),
    .program_finished (program_finished),
    .data_sent        (data_sent),
    .rd_uart          (rd_uart),
    .pipeline_reset   (pipeline_reset),
    .pipeline_clk     (pipeline_clk),
    .send_data        (send_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    global_reset = 1'b0;
    rx_empty = 1'b1;
    r_data = 2'b00;
    program_finished = 1'b0;
    data_sent = 1'b0;
    step();
    step();
    checks++;
    if ({pipeline_reset, rd_uart, send_data, pipeline_clk} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_hold: rst/rd/send/pclk got %b want 1000",
               {pipeline_reset, rd_uart, send_data, pipeline_clk});
    end
    global_reset = 1'b1;
    step();
    checks++;
    if ({pipeline_reset, rd_uart, send_data, pipeline_clk} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: rst/rd/send/pclk got %b want 0000",
               {pipeline_reset, rd_uart, send_data, pipeline_clk});
    end
    step();
    checks++;
    if ({pipeline_reset, rd_uart, send_data, pipeline_clk} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: rst/rd/send/pclk got %b want 0000",
               {pipeline_reset, rd_uart, send_data, pipeline_clk});
    end
  endtask

  task automatic test_run_all();
    r_data = 2'b10;
    rx_empty = 1'b0;
    step();
    rx_empty = 1'b1;
    checks++;
    if ({rd_uart, pipeline_clk} !== 2'b10) begin
      errors++;
      $display("FAIL run_pop: rd/pclk got %b want 10", {rd_uart, pipeline_clk});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({rd_uart, pipeline_clk, send_data} !== {1'b0, (i % 2 == 0), 1'b0}) begin
        errors++;
        $display("FAIL run_toggle[%0d]: rd/pclk/send got %b want 0%b0",
                 i, {rd_uart, pipeline_clk, send_data}, (i % 2 == 0));
      end
    end
    program_finished = 1'b1;
    step();
    program_finished = 1'b0;
    checks++;
    if ({pipeline_clk, send_data, rd_uart} !== 3'b010) begin
      errors++;
      $display("FAIL run_stop: pclk/send/rd got %b want 010",
               {pipeline_clk, send_data, rd_uart});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({pipeline_clk, send_data} !== 2'b01) begin
        errors++;
        $display("FAIL run_send_hold[%0d]: pclk/send got %b want 01", i,
                 {pipeline_clk, send_data});
      end
    end
    data_sent = 1'b1;
    step();
    data_sent = 1'b0;
    checks++;
    if ({pipeline_clk, send_data} !== 2'b00) begin
      errors++;
      $display("FAIL run_send_drop: pclk/send got %b want 00", {pipeline_clk, send_data});
    end
  endtask

  task automatic test_sw_reset();
    r_data = 2'b11;
    rx_empty = 1'b0;
    step();
    rx_empty = 1'b1;
    checks++;
    if ({rd_uart, pipeline_reset, pipeline_clk} !== 3'b100) begin
      errors++;
      $display("FAIL swrst_pop: rd/rst/pclk got %b want 100",
               {rd_uart, pipeline_reset, pipeline_clk});
    end
    step();
    checks++;
    if ({rd_uart, pipeline_reset, pipeline_clk, send_data} !== 4'b0110) begin
      errors++;
      $display("FAIL swrst_hi: rd/rst/pclk/send got %b want 0110",
               {rd_uart, pipeline_reset, pipeline_clk, send_data});
    end
    // data_sent already high on SEND entry: SEND lasts a single cycle
    data_sent = 1'b1;
    step();
    checks++;
    if ({pipeline_reset, pipeline_clk, send_data} !== 3'b100) begin
      errors++;
      $display("FAIL swrst_lo: rst/pclk/send got %b want 100",
               {pipeline_reset, pipeline_clk, send_data});
    end
    step();
    checks++;
    if ({pipeline_reset, pipeline_clk, send_data} !== 3'b001) begin
      errors++;
      $display("FAIL swrst_send: rst/pclk/send got %b want 001",
               {pipeline_reset, pipeline_clk, send_data});
    end
    step();
    data_sent = 1'b0;
    checks++;
    if ({pipeline_reset, send_data, rd_uart} !== 3'b000) begin
      errors++;
      $display("FAIL swrst_short_send: rst/send/rd got %b want 000",
               {pipeline_reset, send_data, rd_uart});
    end
  endtask

  task automatic test_one_step();
    r_data = 2'b01;
    rx_empty = 1'b0;
    step();
    rx_empty = 1'b1;
    checks++;
    if ({rd_uart, pipeline_clk} !== 2'b10) begin
      errors++;
      $display("FAIL step_pop: rd/pclk got %b want 10", {rd_uart, pipeline_clk});
    end
    step();
    checks++;
    if ({rd_uart, pipeline_clk, send_data, pipeline_reset} !== 4'b0100) begin
      errors++;
      $display("FAIL step_hi: rd/pclk/send/rst got %b want 0100",
               {rd_uart, pipeline_clk, send_data, pipeline_reset});
    end
    step();
    checks++;
    if ({pipeline_clk, send_data} !== 2'b00) begin
      errors++;
      $display("FAIL step_lo: pclk/send got %b want 00", {pipeline_clk, send_data});
    end
    step();
    checks++;
    if ({pipeline_clk, send_data} !== 2'b01) begin
      errors++;
      $display("FAIL step_send: pclk/send got %b want 01", {pipeline_clk, send_data});
    end
    step();
    checks++;
    if ({pipeline_clk, send_data} !== 2'b01) begin
      errors++;
      $display("FAIL step_send_hold: pclk/send got %b want 01", {pipeline_clk, send_data});
    end
    data_sent = 1'b1;
    step();
    data_sent = 1'b0;
    checks++;
    if (send_data !== 1'b0) begin
      errors++;
      $display("FAIL step_send_drop: send got %b want 0", send_data);
    end
  endtask

  task automatic test_back_to_back();
    r_data = 2'b10;
    rx_empty = 1'b0;
    step();
    checks++;
    if (rd_uart !== 1'b1) begin
      errors++;
      $display("FAIL queue_pop1: rd got %b want 1", rd_uart);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rd_uart !== 1'b0) begin
        errors++;
        $display("FAIL queue_busy_run[%0d]: rd got %b want 0", i, rd_uart);
      end
    end
    program_finished = 1'b1;
    step();
    program_finished = 1'b0;
    checks++;
    if ({rd_uart, send_data, pipeline_clk} !== 3'b010) begin
      errors++;
      $display("FAIL queue_send: rd/send/pclk got %b want 010",
               {rd_uart, send_data, pipeline_clk});
    end
    r_data = 2'b00;
    data_sent = 1'b1;
    step();
    data_sent = 1'b0;
    checks++;
    if ({rd_uart, send_data} !== 2'b00) begin
      errors++;
      $display("FAIL queue_idle: rd/send got %b want 00", {rd_uart, send_data});
    end
    step();
    rx_empty = 1'b1;
    checks++;
    if (rd_uart !== 1'b1) begin
      errors++;
      $display("FAIL queue_pop2: rd got %b want 1", rd_uart);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rd_uart, pipeline_clk, pipeline_reset, send_data} !== 4'b0000) begin
        errors++;
        $display("FAIL nop_quiet[%0d]: rd/pclk/rst/send got %b want 0000", i,
                 {rd_uart, pipeline_clk, pipeline_reset, send_data});
      end
    end
  endtask

  task automatic test_abort();
    r_data = 2'b10;
    rx_empty = 1'b0;
    step();
    rx_empty = 1'b1;
    step();
    checks++;
    if (pipeline_clk !== 1'b1) begin
      errors++;
      $display("FAIL abort_run_start: pclk got %b want 1", pipeline_clk);
    end
    step();
    step();
    global_reset = 1'b0;
    step();
    checks++;
    if ({pipeline_clk, pipeline_reset, send_data} !== 3'b010) begin
      errors++;
      $display("FAIL abort_reset: pclk/rst/send got %b want 010",
               {pipeline_clk, pipeline_reset, send_data});
    end
    global_reset = 1'b1;
    program_finished = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({pipeline_clk, pipeline_reset, send_data, rd_uart} !== 4'b0000) begin
        errors++;
        $display("FAIL abort_after[%0d]: pclk/rst/send/rd got %b want 0000", i,
                 {pipeline_clk, pipeline_reset, send_data, rd_uart});
      end
    end
    program_finished = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_all();
    test_sw_reset();
    test_one_step();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
